// File: rtl/data_memory_bytelane_if.sv
// Request/response bus for the byte-lane data memory.
// The master issues load/store requests; the slave (memory) returns one
// registered response per accepted request.
interface data_memory_bytelane_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_fault;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_fault
   );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory for the load/store stage.
// Byte/half/word(/dword) loads with sign or zero extension, per-lane stores,
// misalignment/range/size faults, valid/ready handshake with a single
// registered response slot, and a saturating fault counter.
module data_memory_bytelane #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   data_memory_bytelane_if.slave bus,
   output logic [FCNT_WIDTH-1:0] fault_count
);
   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned OFF    = $clog2(NBYTES);
   localparam int unsigned IDXW   = $clog2(DEPTH);
   localparam int unsigned LOW    = OFF + IDXW;
   localparam int unsigned BW     = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_fault_q, resp_fault_d;
   logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

   logic                  accept;
   logic                  wr_en;
   logic [IDXW-1:0]       idx;
   logic [OFF-1:0]        off;
   int unsigned           acc_bytes;
   int unsigned           acc_bits;
   int unsigned           off_bytes;
   logic [ADDR_WIDTH-1:0] align_mask;
   logic [ADDR_WIDTH-1:0] upper;
   logic                  size_fault;
   logic                  align_fault;
   logic                  range_fault;
   logic                  fault;
   logic [NBYTES-1:0]     lane_en;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [DATA_WIDTH-1:0] wword;
   logic [DATA_WIDTH-1:0] rword_sh;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [BW-1:0]         msb_bit;
   logic                  sign_bit;

   assign bus.req_ready  = !resp_valid_q || bus.resp_ready;
   assign accept         = bus.req_valid && bus.req_ready;
   assign idx            = bus.req_addr[LOW-1:OFF];
   assign off            = bus.req_addr[OFF-1:0];
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_fault = resp_fault_q;
   assign fault_count    = fcnt_q;

   // Decode the request: access size, fault checks, lane enables, and load extraction.
   always_comb begin
      acc_bytes   = 32'd1 << bus.req_size;
      acc_bits    = acc_bytes << 3;
      off_bytes   = 32'(off);
      size_fault  = (bus.req_size == 2'b11) && (DATA_WIDTH == 32);
      align_mask  = ADDR_WIDTH'(acc_bytes - 32'd1);
      align_fault = |(bus.req_addr & align_mask);
      upper       = bus.req_addr >> LOW;
      range_fault = |upper;
      fault       = size_fault || align_fault || range_fault;
      wr_en       = accept && bus.req_write && !fault;

      lane_en = '0;
      wmask   = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         lane_en[i]       = (i >= off_bytes) && (i < off_bytes + acc_bytes);
         wmask[8*i +: 8]  = {8{lane_en[i]}};
      end
      wdata_sh = bus.req_wdata << (off_bytes * 8);
      wword    = (mem_q[idx] & ~wmask) | (wdata_sh & wmask);

      // An oversize request wraps msb_bit into range; it is faulted so the value is discarded.
      rword_sh = mem_q[idx] >> (off_bytes * 8);
      msb_bit  = BW'(acc_bits - 32'd1);
      sign_bit = !bus.req_unsigned && rword_sh[msb_bit];
      load_ext = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         load_ext[i] = (i < acc_bits) ? rword_sh[i] : sign_bit;
      end
   end

   // Memory array: merged lane write on accepted, non-faulting stores; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[idx] <= wword;
      end
   end

   // Response slot and fault counter next-state: load on accept, retire on consume.
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_fault_d = resp_fault_q;
      fcnt_d       = fcnt_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_fault_d = fault;
         resp_rdata_d = (fault || bus.req_write) ? '0 : load_ext;
         if (fault && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + FCNT_WIDTH'(1);
         end
      end else if (bus.resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   // Response and counter registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
         fcnt_q       <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_fault_q <= resp_fault_d;
         fcnt_q       <= fcnt_d;
      end
   end
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane: a 32-bit/1024-word instance and a
// 64-bit/64-word instance with a 2-bit fault counter. Expected responses are
// queued at acceptance and compared when the DUT presents them.
module tb_data_memory_bytelane;
   logic        clk;
   logic        rst_n;
   logic [15:0] fc32;
   logic [1:0]  fc64;

   int passed = 0;
   int total  = 0;
   int failed = 0;
   int wt;

   logic [64:0] q32[$];
   logic [64:0] q64[$];
   logic [64:0] e32;
   logic [64:0] e64;

   data_memory_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
   data_memory_bytelane_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

   data_memory_bytelane #(.DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(32), .FCNT_WIDTH(16)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32.slave), .fault_count(fc32)
   );

   data_memory_bytelane #(.DATA_WIDTH(64), .DEPTH(64), .ADDR_WIDTH(32), .FCNT_WIDTH(2)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .bus(b64.slave), .fault_count(fc64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, wait (bounded) for acceptance, queue its expected response.
   task automatic issue(input bit wide, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] er,
                        input logic ef, output int waits);
      logic rdy;
      if (wide) begin
         b64.req_valid = 1'b1; b64.req_write = w; b64.req_size = sz;
         b64.req_unsigned = uns; b64.req_addr = a; b64.req_wdata = wd;
      end else begin
         b32.req_valid = 1'b1; b32.req_write = w; b32.req_size = sz;
         b32.req_unsigned = uns; b32.req_addr = a; b32.req_wdata = wd[31:0];
      end
      waits = 0;
      @(negedge clk);
      rdy = wide ? b64.req_ready : b32.req_ready;
      while (!rdy && waits < 50) begin
         waits++;
         @(negedge clk);
         rdy = wide ? b64.req_ready : b32.req_ready;
      end
      check("accept_bound", {63'd0, rdy}, 64'd1);
      if (wide) q64.push_back({ef, er});
      else      q32.push_back({ef, er});
      @(posedge clk);
      #1;
      if (wide) b64.req_valid = 1'b0;
      else      b32.req_valid = 1'b0;
   endtask

   // Wait (bounded) until all queued responses have been consumed.
   task automatic drain(input bit wide);
      int n = 0;
      while (((wide ? q64.size() : q32.size()) != 0 || (wide ? b64.resp_valid : b32.resp_valid))
             && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_bound", {63'd0, (n < 20)}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (b32.resp_valid && b32.resp_ready) begin
         check("resp32_expected", {63'd0, (q32.size() != 0)}, 64'd1);
         if (q32.size() != 0) begin
            e32 = q32.pop_front();
            check("rdata32", {32'd0, b32.resp_rdata}, e32[63:0]);
            check("fault32", {63'd0, b32.resp_fault}, {63'd0, e32[64]});
         end
      end
   end

   always @(negedge clk) begin
      if (b64.resp_valid && b64.resp_ready) begin
         check("resp64_expected", {63'd0, (q64.size() != 0)}, 64'd1);
         if (q64.size() != 0) begin
            e64 = q64.pop_front();
            check("rdata64", b64.resp_rdata, e64[63:0]);
            check("fault64", {63'd0, b64.resp_fault}, {63'd0, e64[64]});
         end
      end
   end

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      b32.req_valid = 1'b0; b32.req_write = 1'b0; b32.req_size = 2'b00;
      b32.req_unsigned = 1'b0; b32.req_addr = '0; b32.req_wdata = '0; b32.resp_ready = 1'b0;
      b64.req_valid = 1'b0; b64.req_write = 1'b0; b64.req_size = 2'b00;
      b64.req_unsigned = 1'b0; b64.req_addr = '0; b64.req_wdata = '0; b64.resp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", {63'd0, b32.resp_valid}, 64'd0);
      check("rst_resp_rdata", {32'd0, b32.resp_rdata}, 64'd0);
      check("rst_resp_fault", {63'd0, b32.resp_fault}, 64'd0);
      check("rst_fault_count", {48'd0, fc32}, 64'd0);
      check("rst_req_ready", {63'd0, b32.req_ready}, 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      b32.resp_ready = 1'b1;

      // Word store/load and latency
      issue(0, 1, 2'b10, 0, 32'h0,  64'h11223344, 64'h0, 0, wt);
      issue(0, 1, 2'b10, 0, 32'h10, 64'hDEADBEEF, 64'h0, 0, wt);
      issue(0, 0, 2'b10, 0, 32'h10, 64'h0, 64'hDEADBEEF, 0, wt);
      check("load_latency_valid", {63'd0, b32.resp_valid}, 64'd1);

      // Byte store, signed/unsigned byte loads, merged word
      issue(0, 1, 2'b00, 0, 32'h13, 64'h80, 64'h0, 0, wt);
      issue(0, 0, 2'b00, 0, 32'h13, 64'h0, 64'hFFFFFF80, 0, wt);
      issue(0, 0, 2'b00, 1, 32'h13, 64'h0, 64'h00000080, 0, wt);
      issue(0, 0, 2'b10, 0, 32'h10, 64'h0, 64'h80ADBEEF, 0, wt);

      // Half and byte lanes at 0x20; store uses only the low bytes of wdata
      issue(0, 1, 2'b10, 0, 32'h20, 64'h0, 64'h0, 0, wt);
      issue(0, 1, 2'b01, 0, 32'h22, 64'h8001, 64'h0, 0, wt);
      issue(0, 1, 2'b00, 0, 32'h21, 64'hFFFFFF7E, 64'h0, 0, wt);
      issue(0, 0, 2'b10, 0, 32'h20, 64'h0, 64'h80017E00, 0, wt);
      issue(0, 0, 2'b01, 0, 32'h22, 64'h0, 64'hFFFF8001, 0, wt);
      issue(0, 0, 2'b01, 1, 32'h20, 64'h0, 64'h00007E00, 0, wt);
      issue(0, 0, 2'b00, 1, 32'h23, 64'h0, 64'h00000080, 0, wt);
      issue(0, 0, 2'b00, 0, 32'h21, 64'h0, 64'h0000007E, 0, wt);
      drain(0);

      // Faults: misaligned, range, illegal size
      issue(0, 0, 2'b01, 0, 32'h11, 64'h0, 64'h0, 1, wt);
      check("fault_count_1", {48'd0, fc32}, 64'd1);
      issue(0, 1, 2'b10, 0, 32'd4096, 64'hBAD0BAD0, 64'h0, 1, wt);
      check("fault_count_2", {48'd0, fc32}, 64'd2);
      issue(0, 0, 2'b11, 0, 32'h0, 64'h0, 64'h0, 1, wt);
      issue(0, 0, 2'b10, 0, 32'h12, 64'h0, 64'h0, 1, wt);
      check("fault_count_4", {48'd0, fc32}, 64'd4);
      issue(0, 0, 2'b10, 0, 32'h0, 64'h0, 64'h11223344, 0, wt);
      drain(0);

      // Backpressure: first response held, then back-to-back drain
      b32.resp_ready = 1'b0;
      issue(0, 0, 2'b10, 0, 32'h10, 64'h0, 64'h80ADBEEF, 0, wt);
      b32.req_valid = 1'b1; b32.req_write = 1'b0; b32.req_size = 2'b10; b32.req_addr = 32'h20;
      repeat (3) begin
         @(negedge clk);
         check("hold_req_ready", {63'd0, b32.req_ready}, 64'd0);
         check("hold_resp_valid", {63'd0, b32.resp_valid}, 64'd1);
         check("hold_resp_rdata", {32'd0, b32.resp_rdata}, 64'h80ADBEEF);
      end
      @(posedge clk); #1;
      b32.resp_ready = 1'b1;
      issue(0, 0, 2'b10, 0, 32'h20, 64'h0, 64'h80017E00, 0, wt);
      check("b2b_wait_b", wt, 64'd0);
      issue(0, 0, 2'b10, 0, 32'h0, 64'h0, 64'h11223344, 0, wt);
      check("b2b_wait_c", wt, 64'd0);
      issue(0, 0, 2'b00, 1, 32'h13, 64'h0, 64'h00000080, 0, wt);
      check("b2b_wait_d", wt, 64'd0);
      drain(0);

      // Reset while a response is pending; a store presented during reset must not land
      b32.resp_ready = 1'b0;
      issue(0, 0, 2'b10, 0, 32'h10, 64'h0, 64'h80ADBEEF, 0, wt);
      check("pre_reset_valid", {63'd0, b32.resp_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", {63'd0, b32.resp_valid}, 64'd0);
      check("async_reset_rdata", {32'd0, b32.resp_rdata}, 64'd0);
      q32.delete();
      b32.req_valid = 1'b1; b32.req_write = 1'b1; b32.req_size = 2'b10;
      b32.req_addr = 32'h10; b32.req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      b32.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("post_reset_fault_count", {48'd0, fc32}, 64'd0);
      @(posedge clk); #1;
      b32.resp_ready = 1'b1;
      issue(0, 0, 2'b10, 0, 32'h10, 64'h0, 64'h80ADBEEF, 0, wt);
      drain(0);

      // 64-bit instance: dword store, extended loads, faults, counter saturation
      issue(1, 1, 2'b11, 0, 32'h8, 64'h0123456789ABCDEF, 64'h0, 0, wt);
      issue(1, 0, 2'b10, 0, 32'hC, 64'h0, 64'h0000000001234567, 0, wt);
      issue(1, 0, 2'b10, 0, 32'h8, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, wt);
      issue(1, 0, 2'b10, 1, 32'h8, 64'h0, 64'h0000000089ABCDEF, 0, wt);
      issue(1, 0, 2'b11, 1, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, wt);
      issue(1, 0, 2'b01, 0, 32'hA, 64'h0, 64'hFFFFFFFFFFFF89AB, 0, wt);
      issue(1, 0, 2'b00, 1, 32'hF, 64'h0, 64'h0000000000000001, 0, wt);
      issue(1, 0, 2'b11, 0, 32'h4, 64'h0, 64'h0, 1, wt);
      check("fc64_1", {62'd0, fc64}, 64'd1);
      issue(1, 0, 2'b10, 0, 32'h6, 64'h0, 64'h0, 1, wt);
      issue(1, 1, 2'b11, 0, 32'h200, 64'hFFFF, 64'h0, 1, wt);
      check("fc64_3", {62'd0, fc64}, 64'd3);
      issue(1, 0, 2'b00, 0, 32'h1000, 64'h0, 64'h0, 1, wt);
      check("fc64_saturate", {62'd0, fc64}, 64'd3);
      issue(1, 0, 2'b11, 0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, wt);
      drain(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Byte-addressable successor to the single-cycle word data memory, for the CPU load/store stage.
- Adds byte/half/word(/dword) accesses with sign or zero extension and per-lane writes.
- Adds misalignment, range and illegal-size faults, a valid/ready request/response handshake with backpressure, and a saturating fault counter.
- Storage is DEPTH words of DATA_WIDTH bits; one access is accepted per cycle.

Parameters:
DATA_WIDTH, 32, word width in bits; legal values 32 or 64 only; OFF = log2(DATA_WIDTH/8).
DEPTH, 1024, number of words; must be a power of two.
ADDR_WIDTH, 32, width of the byte address.
FCNT_WIDTH, 16, width of the fault counter.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word(32b), 11 dword (legal only if DATA_WIDTH=64).
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-aligned (bits [8*bytes-1:0] used).
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults.
resp_fault  out  1  request faulted.
fault_count  out  FCNT_WIDTH  saturating count of faulted requests.

Behaviour:
- Reset (async assert, sync release): resp_valid=0, resp_rdata=0, resp_fault=0, fault_count=0. Memory contents are not reset and are preserved across reset.
- req_ready = !resp_valid || resp_ready (combinational). A request is accepted when req_valid && req_ready at a rising edge.
- Latency: response is registered; resp_valid=1 on the edge that accepts the request. resp_rdata, resp_fault and resp_valid hold stable until resp_ready.
- Throughput: back-to-back, 1 request/cycle, when resp_ready is held high.
- Address split: word index = req_addr[OFF+log2(DEPTH)-1:OFF]; lane offset = req_addr[OFF-1:0].
- Fault conditions, any one sufficient:
  - size 11 with DATA_WIDTH=32;
  - misaligned: address not a multiple of the access size in bytes;
  - range: req_addr >> OFF >= DEPTH, i.e. any nonzero upper address bits.
- Faulted requests: memory is unchanged, resp_rdata=0, resp_fault=1, fault_count increments and saturates at all-ones.
- Store: the written bytes are lanes [offset, offset+bytes-1], taking req_wdata low bytes; other lanes are unchanged. resp_rdata=0, resp_fault=0.
- Load: selected bytes are shifted down to bit 0 and extended per req_unsigned. A full-width access ignores req_unsigned. A 32-bit access on a 64-bit memory is extended to 64 bits.
- Ordering: a load accepted the cycle after a store to the same word returns the new data.
- Reset asserted mid-transaction: the pending response is dropped, resp_valid=0 immediately, and no partial store occurs for a request not yet accepted.
- Simultaneous consume and accept (resp_valid && resp_ready && req_valid): the old response retires and the new response loads on the same edge, with no bubble.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10; load word at 0x10 -> resp_valid one cycle after accept, resp_rdata=0xDEADBEEF, resp_fault=0.
- Store byte 0x80 at 0x13; load byte signed at 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word at 0x10 -> 0x80ADBEEF.
- Half load at 0x11 -> resp_fault=1, resp_rdata=0, fault_count=1. Store word at address 4*DEPTH -> fault, fault_count=2, and word 0 is unchanged.
- Issue 4 back-to-back loads with resp_ready held low after the first response -> req_ready=0, first response held stable; release resp_ready -> remaining responses return on consecutive cycles, in order.
- Assert rst_n low while resp_valid=1 -> resp_valid=0 asynchronously; after release, load 0x10 still returns 0x80ADBEEF.
- With DATA_WIDTH=64: store dword 0x0123456789ABCDEF at 0x8, then signed word load at 0xC -> 0x0000000001234567; size 11 at 0x4 -> fault.
